wb_reg_file: RTL and testbench

//  Write-back end of the MEM/WB interface: architectural state that the WB-stage outputs
//  (result, reg write enable/addr, HI/LO write enable/data) commit into.

---
 rtl/wb_reg_file_pkg.sv | 35 +++
 rtl/wb_reg_file_hilo_reg.sv | 47 ++++
 rtl/wb_reg_file.sv | 104 ++++++++++
 tb/tb_wb_reg_file.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_reg_file_pkg
// Brief  : Shared widths, constants and read-source helper for the WB register file.
// Rev    : 1.0
// ============================================================================
package wb_reg_file_pkg;

    localparam int DATA_BUS_WIDTH     = 32;
    localparam int REG_ADDR_BUS_WIDTH = 5;

    typedef logic [DATA_BUS_WIDTH-1:0]     data_bus_t;
    typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_bus_t;

    localparam data_bus_t     ZERO_WORD  = '0;
    localparam reg_addr_bus_t REG_ZERO   = '0;
    localparam logic          RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_STORE  = 2'd2
    } rd_src_e;

    // Priority: reset/disabled, then $0, then same-cycle write, then storage.
    function automatic rd_src_e rd_src(input logic rst_lvl, input logic rd_en,
                                       input logic addr_is_zero, input logic wr_hit);
        if (rst_lvl == RST_ACTIVE || !rd_en) return SRC_ZERO;
        if (addr_is_zero)                    return SRC_ZERO;
        if (wr_hit)                          return SRC_BYPASS;
        return SRC_STORE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_reg_file_hilo_reg.sv
`default_nettype none
// ============================================================================
// Module : hilo_reg
// Brief  : HI/LO storage with same-cycle write bypass onto its outputs.
// Rev    : 1.0
// ============================================================================
module hilo_reg
    import wb_reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_BUS_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [DATA_W-1:0] i_lo,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_hi <= DATA_W'(ZERO_WORD);
            r_lo <= DATA_W'(ZERO_WORD);
        end else if (i_we) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
        end
    end

    always_comb begin
        o_hi = r_hi;
        o_lo = r_lo;
        if (rst == RST_ACTIVE) begin
            o_hi = DATA_W'(ZERO_WORD);
            o_lo = DATA_W'(ZERO_WORD);
        end else if (i_we) begin
            o_hi = i_hi;
            o_lo = i_lo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_reg_file.sv
`default_nettype none
// ============================================================================
// Module : wb_reg_file
// Brief  : WB-stage architectural state: 32 GPRs (2R1W, bypassed), HI/LO, commit counter.
// Rev    : 1.0
// ============================================================================
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_BUS_WIDTH,
    parameter int ADDR_W = REG_ADDR_BUS_WIDTH,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_write_reg_en,
    input  logic [ADDR_W-1:0] i_write_reg_addr,
    input  logic [DATA_W-1:0] i_write_reg_data,
    input  logic              i_write_hilo_en,
    input  logic [DATA_W-1:0] i_write_hi_data,
    input  logic [DATA_W-1:0] i_write_lo_data,
    input  logic              i_read_reg1_en,
    input  logic [ADDR_W-1:0] i_read_reg1_addr,
    output logic [DATA_W-1:0] o_read_reg1_data,
    input  logic              i_read_reg2_en,
    input  logic [ADDR_W-1:0] i_read_reg2_addr,
    output logic [DATA_W-1:0] o_read_reg2_data,
    output logic [DATA_W-1:0] o_hi_data,
    output logic [DATA_W-1:0] o_lo_data,
    output logic [CNT_W-1:0]  o_commit_count
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_gpr [NUM_REGS];
    logic [CNT_W-1:0]  r_commit_count;
    logic              w_gpr_we;
    logic              w_hit1;
    logic              w_hit2;
    rd_src_e           w_src1;
    rd_src_e           w_src2;

    assign w_gpr_we = i_write_reg_en && (i_write_reg_addr != ADDR_W'(REG_ZERO));
    assign w_hit1   = i_write_reg_en && (i_write_reg_addr == i_read_reg1_addr);
    assign w_hit2   = i_write_reg_en && (i_write_reg_addr == i_read_reg2_addr);

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst == RST_ACTIVE) begin
                r_gpr[i] <= DATA_W'(ZERO_WORD);
            end else if (w_gpr_we && (i_write_reg_addr == ADDR_W'(i))) begin
                r_gpr[i] <= i_write_reg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_commit_count <= '0;
        end else if (w_gpr_we || i_write_hilo_en) begin
            r_commit_count <= r_commit_count + CNT_W'(1);
        end
    end

    assign o_commit_count = r_commit_count;

    always_comb begin
        w_src1 = rd_src(rst, i_read_reg1_en, i_read_reg1_addr == ADDR_W'(REG_ZERO), w_hit1);
        w_src2 = rd_src(rst, i_read_reg2_en, i_read_reg2_addr == ADDR_W'(REG_ZERO), w_hit2);
    end

    always_comb begin
        o_read_reg1_data = DATA_W'(ZERO_WORD);
        case (w_src1)
            SRC_BYPASS: o_read_reg1_data = i_write_reg_data;
            SRC_STORE:  o_read_reg1_data = r_gpr[i_read_reg1_addr];
            default:    o_read_reg1_data = DATA_W'(ZERO_WORD);
        endcase
    end

    always_comb begin
        o_read_reg2_data = DATA_W'(ZERO_WORD);
        case (w_src2)
            SRC_BYPASS: o_read_reg2_data = i_write_reg_data;
            SRC_STORE:  o_read_reg2_data = r_gpr[i_read_reg2_addr];
            default:    o_read_reg2_data = DATA_W'(ZERO_WORD);
        endcase
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (i_write_hilo_en),
        .i_hi (i_write_hi_data),
        .i_lo (i_write_lo_data),
        .o_hi (o_hi_data),
        .o_lo (o_lo_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_reg_file.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_reg_file
// Brief  : Directed + randomized self-checking bench for wb_reg_file against an array model.
// Rev    : 1.0
// ============================================================================
module tb_wb_reg_file;

    logic        clk;
    logic        rst;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_hwe;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_r1en;
    logic [4:0]  r_r1a;
    logic        r_r2en;
    logic [4:0]  r_r2a;

    logic [31:0] w_rd1, w_rd2, w_hi, w_lo, w_cnt;
    logic [31:0] w_s_rd1, w_s_rd2, w_s_hi, w_s_lo;
    logic [3:0]  w_s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int unsigned m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_reg_file u_dut (
        .clk(clk), .rst(rst),
        .i_write_reg_en(r_we), .i_write_reg_addr(r_waddr), .i_write_reg_data(r_wdata),
        .i_write_hilo_en(r_hwe), .i_write_hi_data(r_hi), .i_write_lo_data(r_lo),
        .i_read_reg1_en(r_r1en), .i_read_reg1_addr(r_r1a), .o_read_reg1_data(w_rd1),
        .i_read_reg2_en(r_r2en), .i_read_reg2_addr(r_r2a), .o_read_reg2_data(w_rd2),
        .o_hi_data(w_hi), .o_lo_data(w_lo), .o_commit_count(w_cnt)
    );

    // Narrow-counter build fed the same stimulus; exercises wrap modulo 16.
    wb_reg_file #(.CNT_W(4)) u_dut_c4 (
        .clk(clk), .rst(rst),
        .i_write_reg_en(r_we), .i_write_reg_addr(r_waddr), .i_write_reg_data(r_wdata),
        .i_write_hilo_en(r_hwe), .i_write_hi_data(r_hi), .i_write_lo_data(r_lo),
        .i_read_reg1_en(r_r1en), .i_read_reg1_addr(r_r1a), .o_read_reg1_data(w_s_rd1),
        .i_read_reg2_en(r_r2en), .i_read_reg2_addr(r_r2a), .o_read_reg2_data(w_s_rd2),
        .o_hi_data(w_s_hi), .o_lo_data(w_s_lo), .o_commit_count(w_s_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
        if (!rst || !en) return 32'd0;
        if (a == 5'd0)   return 32'd0;
        if (r_we && r_waddr == a) return r_wdata;
        return m_gpr[a];
    endfunction

    task automatic check_all();
        check_eq("rd1", w_rd1, model_read(r_r1en, r_r1a));
        check_eq("rd2", w_rd2, model_read(r_r2en, r_r2a));
        check_eq("hi",  w_hi,  !rst ? 32'd0 : (r_hwe ? r_hi : m_hi));
        check_eq("lo",  w_lo,  !rst ? 32'd0 : (r_hwe ? r_lo : m_lo));
        check_eq("cnt", w_cnt, m_cnt);
        check_eq("cnt4", {28'd0, w_s_cnt}, {28'd0, m_cnt[3:0]});
        check_eq("c4_rd1", w_s_rd1, model_read(r_r1en, r_r1a));
    endtask

    // Apply current inputs for one cycle: check outputs, clock, update model.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_cnt = 0;
        end else begin
            if (r_we && r_waddr != 5'd0) m_gpr[r_waddr] = r_wdata;
            if (r_hwe) begin
                m_hi = r_hi;
                m_lo = r_lo;
            end
            if ((r_we && r_waddr != 5'd0) || r_hwe) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        r_we = 1'b0; r_waddr = 5'd0; r_wdata = 32'd0;
        r_hwe = 1'b0; r_hi = 32'd0; r_lo = 32'd0;
        r_r1en = 1'b0; r_r1a = 5'd0; r_r2en = 1'b0; r_r2a = 5'd0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            r_r1en = 1'b1; r_r1a = 5'(a);
            r_r2en = 1'b1; r_r2a = 5'(31 - a);
            tick();
        end

        idle();
        r_we = 1'b1; r_waddr = 5'd5; r_wdata = 32'hDEADBEEF;
        r_r1en = 1'b1; r_r1a = 5'd5;
        #1 check_eq("t2_bypass", w_rd1, 32'hDEADBEEF);
        tick();
        r_we = 1'b0;
        #1 check_eq("t2_stored", w_rd1, 32'hDEADBEEF);
        check_eq("t2_cnt", w_cnt, 32'd1);
        tick();

        idle();
        r_we = 1'b1; r_waddr = 5'd0; r_wdata = 32'h12345678;
        r_r1en = 1'b1; r_r2en = 1'b1;
        tick();
        r_we = 1'b0;
        tick();

        idle();
        r_hwe = 1'b1; r_hi = 32'h1; r_lo = 32'h2;
        r_we = 1'b1; r_waddr = 5'd3; r_wdata = 32'd7;
        r_r1en = 1'b1; r_r1a = 5'd3;
        tick();
        idle();
        r_r1en = 1'b1; r_r1a = 5'd3; r_r2en = 1'b0; r_r2a = 5'd3;
        #1 check_eq("t5_rd1", w_rd1, 32'd7);
        check_eq("t5_rd2_off", w_rd2, 32'd0);
        check_eq("t4_cnt", w_cnt, 32'd2);
        tick();

        r_we = 1'b1; r_waddr = 5'd9; r_wdata = 32'hA5A5A5A5; r_hwe = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        r_r1en = 1'b1; r_r1a = 5'd9; r_r2en = 1'b1; r_r2a = 5'd5;
        #1 check_eq("t6_rd9", w_rd1, 32'd0);
        check_eq("t6_cnt", w_cnt, 32'd0);
        tick();

        // Small-address bias keeps write/read collisions and $0 writes frequent.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 39) != 0);
            r_we    = ($urandom_range(0, 3) != 0);
            r_waddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r_wdata = $urandom;
            r_hwe   = ($urandom_range(0, 3) == 0);
            r_hi    = $urandom;
            r_lo    = $urandom;
            r_r1en  = ($urandom_range(0, 5) != 0);
            r_r1a   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r_r2en  = ($urandom_range(0, 5) != 0);
            r_r2a   = ($urandom_range(0, 2) == 0) ? r_r1a : 5'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
